// File: rtl/perm_seq_if.sv
// perm_seq bus: NoC lane streams, lane-memory ports and round-engine handshake.
// master = the sequencer, slave = NoC source/sink, m55 banks and engine.
interface perm_seq_if #(
    parameter int DW = 64
);
    logic          pushin;
    logic          firstin;
    logic [DW-1:0] din;
    logic          stopin;
    logic [2:0]    lwx;
    logic [2:0]    lwy;
    logic          lwr;
    logic [DW-1:0] lwd;
    logic          rsel;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [DW-1:0] rd;
    logic          rnd_go;
    logic [4:0]    rnd_num;
    logic          rnd_src;
    logic          rnd_done;
    logic          pushout;
    logic          firstout;
    logic [DW-1:0] dout;
    logic          stopout;

    modport master (
        input  pushin, firstin, din, rd,
        input  rnd_done, stopout,
        output stopin, lwx, lwy, lwr, lwd,
        output rsel, rx, ry,
        output rnd_go, rnd_num, rnd_src,
        output pushout, firstout, dout
    );

    modport slave (
        output pushin, firstin, din, rd,
        output rnd_done, stopout,
        input  stopin, lwx, lwy, lwr, lwd,
        input  rsel, rx, ry,
        input  rnd_go, rnd_num, rnd_src,
        input  pushout, firstout, dout
    );
endinterface

// File: rtl/perm_seq.sv
// perm_seq: load 25 lanes, run ROUNDS ping-pong rounds, drain 25 lanes.
// Optional PERM_SEQ_PERF_EN adds perm_cnt / stall_cnt counters.
module perm_seq #(
    parameter int ROUNDS = 24,
    parameter int DW     = 64
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PERM_SEQ_PERF_EN
    output logic [15:0] perm_cnt,
    output logic [15:0] stall_cnt,
`endif
    perm_seq_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    state_t        state;
    state_t        state_nx;

    // Shared lane cursor: write position in LOAD, read position in DRAIN.
    logic [2:0]    cx;
    logic [2:0]    cy;
    logic [4:0]    rnum;
    logic          rsrc;
    logic          rsel_q;

    // Drain pipeline: read in flight, output register, skid register.
    logic          rdone;
    logic          pend;
    logic          ovalid;
    logic          svalid;
    logic [DW-1:0] obuf;
    logic [DW-1:0] sbuf;
    logic [4:0]    ocnt;

    logic          in_load;
    logic          wr_en;
    logic          cur_last;
    logic          out_xfer;
    logic          out_last;
    logic          issue;
    logic [1:0]    occ;

    assign in_load  = (state == IDLE) || (state == LOAD);
    assign wr_en    = in_load && bus.pushin &&
                      (bus.firstin || state == LOAD);
    assign cur_last = (cx == 3'd4) && (cy == 3'd4);
    assign out_xfer = (state == DRAIN) && ovalid && !bus.stopout;
    assign out_last = out_xfer && (ocnt == 5'd24);

    // Lanes held or in flight after this cycle's transfer; a new read
    // is only issued while one slot remains, so the skid never overflows.
    assign occ   = {1'b0, ovalid} + {1'b0, svalid} + {1'b0, pend}
                 - {1'b0, out_xfer};
    assign issue = (state == DRAIN) && !rdone && (occ <= 2'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (wr_en) state_nx = LOAD;
            LOAD: begin
                if (wr_en && !bus.firstin && cur_last)
                    state_nx = RUN;
            end
            RUN:   state_nx = WAIT;
            WAIT: begin
                if (bus.rnd_done)
                    state_nx = (rnum == LAST_RND) ? DRAIN : RUN;
            end
            DRAIN: if (out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane cursor, round index/source bank and drain bank select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cx     <= 3'd0;
            cy     <= 3'd0;
            rnum   <= 5'd0;
            rsrc   <= 1'b0;
            rsel_q <= 1'b0;
            rdone  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    if (wr_en) begin
                        if (bus.firstin) begin
                            cx <= 3'd1;
                            cy <= 3'd0;
                        end else if (cur_last) begin
                            cx   <= 3'd0;
                            cy   <= 3'd0;
                            rnum <= 5'd0;
                            rsrc <= 1'b0;
                        end else if (cx == 3'd4) begin
                            cx <= 3'd0;
                            cy <= cy + 3'd1;
                        end else begin
                            cx <= cx + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.rnd_done) begin
                        if (rnum == LAST_RND) begin
                            rsel_q <= ~rsrc;
                            cx     <= 3'd0;
                            cy     <= 3'd0;
                            rdone  <= 1'b0;
                        end else begin
                            rnum <= rnum + 5'd1;
                            rsrc <= ~rsrc;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        if (cur_last) begin
                            cx    <= 3'd0;
                            cy    <= 3'd0;
                            rdone <= 1'b1;
                        end else if (cx == 3'd4) begin
                            cx <= 3'd0;
                            cy <= cy + 3'd1;
                        end else begin
                            cx <= cx + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Drain output/skid registers and transferred-lane count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend   <= 1'b0;
            ovalid <= 1'b0;
            svalid <= 1'b0;
            obuf   <= '0;
            sbuf   <= '0;
            ocnt   <= 5'd0;
        end else if (state != DRAIN) begin
            pend   <= 1'b0;
            ovalid <= 1'b0;
            svalid <= 1'b0;
            ocnt   <= 5'd0;
        end else begin
            pend <= issue;
            if (!ovalid || out_xfer) begin
                if (svalid) begin
                    obuf   <= sbuf;
                    ovalid <= 1'b1;
                    svalid <= pend;
                    if (pend) sbuf <= bus.rd;
                end else begin
                    ovalid <= pend;
                    if (pend) obuf <= bus.rd;
                end
            end else if (pend) begin
                sbuf   <= bus.rd;
                svalid <= 1'b1;
            end
            if (out_xfer) ocnt <= ocnt + 5'd1;
        end
    end

    // Bus outputs decoded from state.
    always_comb begin
        bus.stopin   = 1'b0;
        bus.lwr      = 1'b0;
        bus.lwx      = 3'd0;
        bus.lwy      = 3'd0;
        bus.lwd      = '0;
        bus.rx       = 3'd0;
        bus.ry       = 3'd0;
        bus.rnd_go   = 1'b0;
        bus.pushout  = 1'b0;
        bus.firstout = 1'b0;
        bus.dout     = '0;
        bus.rsel     = rsel_q;
        bus.rnd_num  = rnum;
        bus.rnd_src  = rsrc;
        unique case (state)
            IDLE, LOAD: begin
                bus.lwr = wr_en;
                if (wr_en) begin
                    bus.lwd = bus.din;
                    if (!bus.firstin) begin
                        bus.lwx = cx;
                        bus.lwy = cy;
                    end
                end
            end
            RUN: begin
                bus.stopin = 1'b1;
                bus.rnd_go = 1'b1;
            end
            WAIT: bus.stopin = 1'b1;
            DRAIN: begin
                bus.stopin   = 1'b1;
                bus.rx       = cx;
                bus.ry       = cy;
                bus.pushout  = ovalid;
                bus.firstout = ovalid && (ocnt == 5'd0);
                if (ovalid) bus.dout = obuf;
            end
            default: ;
        endcase
    end

`ifdef PERM_SEQ_PERF_EN
    // Completed permutations and stalled output cycles, wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perm_cnt  <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (out_last)
                perm_cnt <= perm_cnt + 16'd1;
            if (state == DRAIN && ovalid && bus.stopout)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_perm_seq.sv
// Bench for perm_seq: two instances (24 and 3 rounds) with bank/engine
// models; expected lanes are queued at load, checked by a monitor.
module tb_perm_seq;
    localparam int DW = 64;
    localparam int R0 = 24;
    localparam int R1 = 3;

    typedef struct {
        logic [63:0] d;
        logic        f;
        logic        s;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        pushin_d;
    logic        firstin_d;
    logic [63:0] din_d;
    logic        stopout_d;

    int   nvec;
    int   nerr;
    int   go_cnt;
    int   go_base;
    int   out_cnt;
    int   stalls0;
    exp_t exp_q[$];

    perm_seq_if #(.DW(DW)) if0 ();
    perm_seq_if #(.DW(DW)) if1 ();

`ifdef PERM_SEQ_PERF_EN
    logic [15:0] pc0, sc0, pc1, sc1;
`endif

    perm_seq #(.ROUNDS(R0), .DW(DW)) u0 (
        .clk(clk),
        .rst(rst),
`ifdef PERM_SEQ_PERF_EN
        .perm_cnt(pc0),
        .stall_cnt(sc0),
`endif
        .bus(if0)
    );

    perm_seq #(.ROUNDS(R1), .DW(DW)) u1 (
        .clk(clk),
        .rst(rst),
`ifdef PERM_SEQ_PERF_EN
        .perm_cnt(pc1),
        .stall_cnt(sc1),
`endif
        .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        done_m [2];
    logic [63:0] rd_m   [2];
    logic        go_v   [2];
    logic        src_v  [2];
    logic        wr_v   [2];
    logic        rs_v   [2];
    logic [2:0]  wx_v   [2];
    logic [2:0]  wy_v   [2];
    logic [2:0]  qx_v   [2];
    logic [2:0]  qy_v   [2];
    logic [63:0] wd_v   [2];

    assign if0.pushin   = pushin_d & ~sel;
    assign if1.pushin   = pushin_d & sel;
    assign if0.firstin  = firstin_d;
    assign if1.firstin  = firstin_d;
    assign if0.din      = din_d;
    assign if1.din      = din_d;
    assign if0.stopout  = stopout_d;
    assign if1.stopout  = stopout_d;
    assign if0.rnd_done = done_m[0];
    assign if1.rnd_done = done_m[1];
    assign if0.rd       = rd_m[0];
    assign if1.rd       = rd_m[1];

    assign go_v[0]  = if0.rnd_go;
    assign go_v[1]  = if1.rnd_go;
    assign src_v[0] = if0.rnd_src;
    assign src_v[1] = if1.rnd_src;
    assign wr_v[0]  = if0.lwr;
    assign wr_v[1]  = if1.lwr;
    assign rs_v[0]  = if0.rsel;
    assign rs_v[1]  = if1.rsel;
    assign wx_v[0]  = if0.lwx;
    assign wx_v[1]  = if1.lwx;
    assign wy_v[0]  = if0.lwy;
    assign wy_v[1]  = if1.lwy;
    assign qx_v[0]  = if0.rx;
    assign qx_v[1]  = if1.rx;
    assign qy_v[0]  = if0.ry;
    assign qy_v[1]  = if1.ry;
    assign wd_v[0]  = if0.lwd;
    assign wd_v[1]  = if1.lwd;

    logic        pushout_m, firstout_m, rsel_m, stopin_m;
    logic        go_m, rsrc_m, lwr_m;
    logic [4:0]  rnum_m;
    logic [2:0]  lwx_m, lwy_m;
    logic [63:0] dout_m, lwd_m;

    assign pushout_m  = sel ? if1.pushout  : if0.pushout;
    assign firstout_m = sel ? if1.firstout : if0.firstout;
    assign rsel_m     = sel ? if1.rsel     : if0.rsel;
    assign stopin_m   = sel ? if1.stopin   : if0.stopin;
    assign go_m       = sel ? if1.rnd_go   : if0.rnd_go;
    assign rsrc_m     = sel ? if1.rnd_src  : if0.rnd_src;
    assign rnum_m     = sel ? if1.rnd_num  : if0.rnd_num;
    assign lwr_m      = sel ? if1.lwr      : if0.lwr;
    assign lwx_m      = sel ? if1.lwx      : if0.lwx;
    assign lwy_m      = sel ? if1.lwy      : if0.lwy;
    assign lwd_m      = sel ? if1.lwd      : if0.lwd;
    assign dout_m     = sel ? if1.dout     : if0.dout;

    function automatic int lane(input logic [2:0] x, input logic [2:0] y);
        return int'(x) + 5 * int'(y);
    endfunction

    // m55 banks (A=0, B=1) and an engine that adds 1 to every lane.
    logic [63:0] bank [2][2][25];
    int          ecnt [2];
    logic        esrc [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            done_m[d] <= 1'b0;
            rd_m[d]   <= bank[d][rs_v[d]][lane(qx_v[d], qy_v[d])];
            if (wr_v[d])
                bank[d][0][lane(wx_v[d], wy_v[d])] <= wd_v[d];
            if (ecnt[d] != 0) begin
                ecnt[d] <= ecnt[d] - 1;
                if (ecnt[d] == 1) begin
                    done_m[d] <= 1'b1;
                    for (int i = 0; i < 25; i++)
                        bank[d][~esrc[d]][i] <= bank[d][esrc[d]][i] + 64'd1;
                end
            end else if (go_v[d]) begin
                ecnt[d] <= 2;
                esrc[d] <= src_v[d];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Monitor: round pulses, held output under stall, lane scoreboard.
    initial begin : mon
        logic        prev_stall;
        logic [63:0] prev_dout;
        exp_t        e;
        int          g;
        prev_stall = 1'b0;
        prev_dout  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (go_m) begin
                g = go_cnt - go_base;
                chk("rnd_num", 64'(rnum_m), 64'(g));
                chk("rnd_src", 64'(rsrc_m), 64'(g[0]));
                go_cnt++;
            end
            if (prev_stall) begin
                chk("hold_push", 64'(pushout_m), 64'd1);
                chk("hold_dout", dout_m, prev_dout);
            end
            if (pushout_m && !stopout_d) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL extra_lane: got %0h, want none", dout_m);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout_m, e.d);
                    chk("firstout", 64'(firstout_m), 64'(e.f));
                    chk("rsel", 64'(rsel_m), 64'(e.s));
                end
                out_cnt++;
            end
            if (pushout_m && stopout_d && !sel) stalls0++;
            prev_stall = pushout_m && stopout_d;
            prev_dout  = dout_m;
        end
    end

    task automatic send(input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            pushin_d  = 1'b1;
            firstin_d = (k == 0);
            din_d     = base + 64'(k);
            @(negedge clk);
            chk("lwr", 64'(lwr_m), 64'd1);
            chk("lwx", 64'(lwx_m), 64'(k % 5));
            chk("lwy", 64'(lwy_m), 64'(k / 5));
            chk("lwd", lwd_m, base + 64'(k));
            chk("stopin_load", 64'(stopin_m), 64'd0);
        end
        @(posedge clk);
        #1;
        pushin_d  = 1'b0;
        firstin_d = 1'b0;
        din_d     = '0;
        @(negedge clk);
        chk("stopin_after_load", 64'(stopin_m), 64'(n == 25));
    endtask

    task automatic run_drain(input bit bp, input int r);
        int k;
        int dk;
        int t0;
        bit seen;
        k    = 0;
        dk   = 0;
        seen = 1'b0;
        t0   = out_cnt;
        while ((out_cnt - t0) < 25 && k < 3000) begin
            @(posedge clk);
            #1;
            if (pushout_m) seen = 1'b1;
            stopout_d = bp && (dk < 2 || dk[0]);
            if (seen) dk++;
            k++;
        end
        stopout_d = 1'b0;
        chk("xfer_count", 64'(out_cnt - t0), 64'd25);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("go_count", 64'(go_cnt - go_base), 64'(r));
        @(negedge clk);
        chk("stopin_idle", 64'(stopin_m), 64'd0);
    endtask

    task automatic perm(input logic [63:0] base, input int r,
                        input bit bp, input bit s);
        exp_t e;
        go_base = go_cnt;
        for (int k = 0; k < 25; k++) begin
            e.d = base + 64'(k) + 64'(r);
            e.f = (k == 0);
            e.s = s;
            exp_q.push_back(e);
        end
        send(base, 25);
        run_drain(bp, r);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int k;
        int g;
        nvec      = 0;
        nerr      = 0;
        go_cnt    = 0;
        go_base   = 0;
        out_cnt   = 0;
        stalls0   = 0;
        rst       = 1'b0;
        sel       = 1'b0;
        pushin_d  = 1'b0;
        firstin_d = 1'b0;
        din_d     = '0;
        stopout_d = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stopin", 64'(if0.stopin), 64'd0);
        chk("rst_lwr", 64'(if0.lwr), 64'd0);
        chk("rst_lwx", 64'(if0.lwx), 64'd0);
        chk("rst_lwy", 64'(if0.lwy), 64'd0);
        chk("rst_lwd", if0.lwd, 64'd0);
        chk("rst_rsel", 64'(if0.rsel), 64'd0);
        chk("rst_rx", 64'(if0.rx), 64'd0);
        chk("rst_ry", 64'(if0.ry), 64'd0);
        chk("rst_go", 64'(if0.rnd_go), 64'd0);
        chk("rst_rnum", 64'(if0.rnd_num), 64'd0);
        chk("rst_rsrc", 64'(if0.rnd_src), 64'd0);
        chk("rst_push", 64'(if0.pushout), 64'd0);
        chk("rst_first", 64'(if0.firstout), 64'd0);
        chk("rst_dout", if0.dout, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        perm(64'h0, R0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pushin_d  = 1'b1;
            firstin_d = 1'b0;
            din_d     = 64'hdead0 + 64'(i);
            @(negedge clk);
            chk("stray_lwr", 64'(lwr_m), 64'd0);
            chk("stray_stopin", 64'(stopin_m), 64'd0);
        end
        perm(64'h5000, R0, 1'b1, 1'b0);

        send(64'hAAA0, 10);
        perm(64'h200, R0, 1'b0, 1'b0);

`ifdef PERM_SEQ_PERF_EN
        chk("perm_cnt", 64'(pc0), 64'd3);
        chk("stall_cnt", 64'(sc0), 64'(stalls0));
`endif

        sel = 1'b1;
        perm(64'h300, R1, 1'b0, 1'b1);

        go_base = go_cnt;
        send(64'h600, 25);
        k = 0;
        while ((go_cnt - go_base) < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached", 64'(go_cnt - go_base), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_stopin", 64'(stopin_m), 64'd0);
        chk("abort_rnum", 64'(rnum_m), 64'd0);
        chk("abort_rsrc", 64'(rsrc_m), 64'd0);
        chk("abort_rsel", 64'(rsel_m), 64'd0);
        chk("abort_push", 64'(pushout_m), 64'd0);
        g = go_cnt;
        repeat (30) @(negedge clk);
        chk("abort_no_go", 64'(go_cnt), 64'(g));
        chk("abort_no_out", 64'(exp_q.size()), 64'd0);

        perm(64'h400, R1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/perm_seq.md
Name: perm_seq

Overview:
- Sequencer for the 5x5x64-bit permutation datapath.
- Accepts a 25-lane state from the NoC-side stream into a lane memory.
- Drives a single-round engine for ROUNDS rounds, ping-ponging between two m55 banks (A/B), then streams the 25 result lanes back out.
- Sits between noc_intf and the round engine / m55 instances; the engine itself is not part of this block.

Parameters:
- ROUNDS, 24, number of rounds per permutation (1..31).
- DW, 64, lane width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- pushin  in  1  input lane valid
- firstin  in  1  marks lane 0 of a state
- din  in  DW  input lane
- stopin  out  1  back-pressure to source
- lwx  out  3  load write x
- lwy  out  3  load write y
- lwr  out  1  load write enable, always to bank A
- lwd  out  DW  load write data
- rsel  out  1  drain read bank (0=A, 1=B)
- rx  out  3  drain read x
- ry  out  3  drain read y
- rd  in  DW  read data from selected bank, valid one cycle after rx/ry
- rnd_go  out  1  one-cycle round start pulse
- rnd_num  out  5  current round index
- rnd_src  out  1  bank the round reads (destination is ~rnd_src)
- rnd_done  in  1  one-cycle round completion pulse
- pushout  out  1  output lane valid
- firstout  out  1  marks lane 0 of output
- dout  out  DW  output lane
- stopout  in  1  downstream back-pressure

Behaviour:
- Reset: rst==0 at a clk edge gives state IDLE, lane counter 0, rnd_num 0, rnd_src 0, rsel 0. All outputs are 0 except stopin=0. Reset mid-operation aborts immediately; no partial output is completed.
- Lane order: lane i = x+5y, x inner (0..4), y outer (0..4), i = 0..24. Both load and drain use this order.
- A lane is accepted when pushin && !stopin.
- IDLE:
  - stopin=0.
  - An accepted lane with firstin=1 writes lane 0 (lwr=1, lwx=0, lwy=0, lwd=din) in the same cycle and moves to LOAD with count=1.
  - Accepted lanes without firstin are dropped: no write.
- LOAD:
  - stopin=0.
  - Each accepted lane writes at the current count, then count increments.
  - firstin=1 mid-load restarts: the lane is written as lane 0 and count becomes 1.
  - After lane 24 is written: go to RUN with rnd_num=0 and rnd_src=0. stopin goes high the next cycle.
- RUN:
  - stopin=1.
  - rnd_go=1 for exactly one cycle with rnd_num and rnd_src valid, then go to WAIT.
- WAIT:
  - stopin=1.
  - rnd_num and rnd_src are held stable.
  - On rnd_done: if rnd_num==ROUNDS-1, go to DRAIN with rsel=~rnd_src. Otherwise rnd_num+=1, rnd_src toggles, go to RUN.
  - rnd_done seen in any state other than WAIT is ignored.
- DRAIN:
  - stopin=1.
  - Reads are issued at lane order; rd is captured into a one-entry output register and a one-entry skid register.
  - Output register full gives pushout=1. While stopout=1, pushout and dout hold unchanged.
  - A lane transfers when pushout && !stopout. A new read is issued only if it cannot overflow the skid, so no lane is lost or duplicated under arbitrary stopout patterns.
  - firstout=1 only with lane 0.
  - After lane 24 transfers: return to IDLE, stopin=0 the next cycle.
- With ROUNDS even, the result is in bank A (rsel=0); with ROUNDS odd, it is in bank B.
- Throughput:
  - LOAD: one lane per cycle.
  - DRAIN: one lane per cycle when stopout=0. First pushout comes 2 cycles after entering DRAIN.
  - Round overhead: 2 cycles (RUN plus rnd_done sampling) plus engine latency.

Optional Feature:
- Macro: PERM_SEQ_PERF_EN.
- Defined: adds outputs perm_cnt[15:0] and stall_cnt[15:0], both 0 on reset.
  - perm_cnt increments when lane 24 transfers in DRAIN.
  - stall_cnt increments each DRAIN cycle with pushout && stopout.
  - Both wrap at 16 bits.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic flow:
  - Stimulus: 25 lanes din=i (firstin on i=0, no gaps), ROUNDS=24, engine model returns rnd_done 3 cycles after rnd_go.
  - Required: rnd_go 24 times with rnd_num 0..23 and rnd_src alternating 0,1,...
  - Required: rsel=0; dout sequence reads lanes 0..24 at (x,y) = (0,0),(1,0)..(4,4); firstout only on the first.
- Stray lanes: pushin with firstin=0 in IDLE for 3 cycles -> lwr stays 0; a following firstin lane writes lwx=0, lwy=0.
- Load restart: firstin reasserted at count 10 -> lane written at (0,0); 25 further lanes are required before RUN.
- Back-pressure: stopout toggling 1,1,0,1,0... during DRAIN -> exactly 25 transfers, no lane dropped or duplicated, dout stable while stalled.
- Odd rounds and reset abort:
  - ROUNDS=3 -> 3 rnd_go pulses and rsel=1.
  - rst=0 during WAIT -> IDLE, rnd_go never pulses again, stopin=0 after reset.
- PERF: with PERM_SEQ_PERF_EN, two complete permutations with 4 stalled output cycles -> perm_cnt=2, stall_cnt=4.
